// File: rtl/sram_arb_pkg.sv
// Shared types and address window for the SRAM data-port arbiter.
// The window constants are also used where the SRAM wrapper is instantiated.
package sram_arb_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] SRAM_END_ADDR  = 32'h8000_C000;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  // Owner/pointer index width; at least one bit so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr,
// wrapping modulo NUM_MASTERS.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int IDX_W = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [IDX_W:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid                 = 1'b1;
        idx                   = cand[IDX_W-1:0];
        gnt[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin OBI arbiter sharing the SRAM data port; one transaction in flight,
// out-of-window accesses answered locally with an error response.
module sram_port_arbiter #(
  parameter int          NUM_MASTERS    = 2,
  parameter logic [31:0] SRAM_BASE_ADDR = sram_arb_pkg::SRAM_BASE_ADDR,
  parameter logic [31:0] SRAM_END_ADDR  = sram_arb_pkg::SRAM_END_ADDR
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  input  logic [NUM_MASTERS*32-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*4-1:0]  m_be_i,
  input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]    m_rvalid_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               m_rdata_o,
  output logic                      s_req_o,
  output logic [31:0]               s_addr_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  output logic [31:0]               s_wdata_o,
  input  logic                      s_gnt_i,
  input  logic                      s_rvalid_i,
  input  logic [31:0]               s_rdata_i,
  output logic                      illegal_o
);

  import sram_arb_pkg::*;

  localparam int IDX_W = idx_width(NUM_MASTERS);

  // Word-granular window compare; byte offset bits never matter.
  function automatic logic in_window(input logic [29:0] word);
    return (word >= SRAM_BASE_ADDR[31:2]) && (word < SRAM_END_ADDR[31:2]);
  endfunction

  logic                   pending;
  logic                   err_pending;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       rr_ptr;

  obi_req_t               reqs [NUM_MASTERS];
  obi_req_t               sel;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;
  logic                   legal;
  logic                   can_issue;
  logic                   issue;
  logic                   accept;
  logic                   resp_valid;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign reqs[g] = '{addr:  m_addr_i[32*g +: 32],
                       we:    m_we_i[g],
                       be:    m_be_i[4*g +: 4],
                       wdata: m_wdata_i[32*g +: 32]};
  end

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr (
    .req    (m_req_i),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  assign sel       = reqs[arb_idx];
  assign legal     = in_window(sel.addr[31:2]);
  // Issuing in the response cycle keeps back-to-back throughput at one per cycle.
  assign can_issue = !pending || err_pending || s_rvalid_i;
  assign issue     = !rst_i && can_issue && arb_valid;
  assign accept    = issue && (!legal || s_gnt_i);
  assign resp_valid = !rst_i && pending && (err_pending || s_rvalid_i);

  assign s_req_o   = issue && legal;
  assign s_addr_o  = sel.addr;
  assign s_we_o    = sel.we;
  assign s_be_o    = sel.be;
  assign s_wdata_o = sel.wdata;
  assign m_gnt_o   = (issue && (!legal || s_gnt_i)) ? arb_gnt : '0;

  assign m_rvalid_o = resp_valid ? (NUM_MASTERS'(1) << owner) : '0;
  assign m_err_o    = (resp_valid && err_pending) ? (NUM_MASTERS'(1) << owner) : '0;
  assign m_rdata_o  = (resp_valid && !err_pending) ? s_rdata_i : '0;
  assign illegal_o  = resp_valid && err_pending;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending     <= 1'b0;
      err_pending <= 1'b0;
      owner       <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      pending     <= 1'b1;
      err_pending <= !legal;
      owner       <= arb_idx;
      rr_ptr      <= (arb_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : arb_idx + 1'b1;
    end else if (resp_valid) begin
      pending     <= 1'b0;
      err_pending <= 1'b0;
    end
  end

endmodule
